// File: rtl/decode_issue_stage_pkg.sv
// Shared types for the decode/issue stage.
//   reg_id_t      : register index, wide enough for up to 256 GPRs
//   score_entry_t : one scoreboard slot {valid, rd}
//   CTRL_NOP      : control word loaded on a bubble; sliced to CTRL_W by users
package decode_issue_stage_pkg;
  localparam int REG_ID_W   = 8;
  localparam int CTRL_W_MAX = 64;

  typedef logic [REG_ID_W-1:0] reg_id_t;

  typedef struct packed {
    logic    valid;
    reg_id_t rd;
  } score_entry_t;

  localparam logic [CTRL_W_MAX-1:0] CTRL_NOP = '0;
endpackage

// File: rtl/hazard_scoreboard.sv
// Shift-register scoreboard of pending register writes.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   shift                   pipeline advances; entries move one slot down
//   insert_valid, insert_rd entry written into slot 0 on shift
//   clear_head              invalidate slot 0 (squash of the out register)
//   rs1, rs2                source indices to look up
//   rs1_match, rs2_match    some valid entry targets rs1 / rs2
module hazard_scoreboard
  import decode_issue_stage_pkg::*;
#(
  parameter int HAZ_DEPTH = 3,
  parameter int RW        = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          shift,
  input  logic          insert_valid,
  input  logic [RW-1:0] insert_rd,
  input  logic          clear_head,
  input  logic [RW-1:0] rs1,
  input  logic [RW-1:0] rs2,
  output logic          rs1_match,
  output logic          rs2_match
);
  score_entry_t sb [HAZ_DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < HAZ_DEPTH; k++) sb[k] <= '0;
    end else if (shift) begin
      for (int k = 1; k < HAZ_DEPTH; k++) sb[k] <= sb[k-1];
      sb[0].valid <= insert_valid & ~clear_head;
      sb[0].rd    <= REG_ID_W'(insert_rd);
    end else if (clear_head) begin
      sb[0].valid <= 1'b0;
    end
  end

  always_comb begin
    rs1_match = 1'b0;
    rs2_match = 1'b0;
    for (int k = 0; k < HAZ_DEPTH; k++) begin
      if (sb[k].valid && sb[k].rd == REG_ID_W'(rs1)) rs1_match = 1'b1;
      if (sb[k].valid && sb[k].rd == REG_ID_W'(rs2)) rs2_match = 1'b1;
    end
  end
endmodule

// File: rtl/decode_issue_stage.sv
// Decode/issue stage: holds decoded instructions back on RAW hazards
// against in-flight writes and for a fixed shadow after branches, and
// registers the issued instruction for execute.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   in_valid/in_ready                decoded-instruction handshake
//   in_pc, in_rs1/2, in_rd, flags    decoded instruction fields
//   in_ctrl                          opaque ALU/memory control word
//   rs1_val, rs2_val                 register-file read data
//   flush                            squash from execute
//   out_ready                        downstream advances
//   out_*                            registered issued instruction
//   stall_out, stall_count           stall indication and saturating count
module decode_issue_stage
  import decode_issue_stage_pkg::*;
#(
  parameter int  XLEN      = 32,
  parameter int  NREG      = 32,
  parameter int  CTRL_W    = 24,
  parameter int  HAZ_DEPTH = 3,
  parameter int  BR_SHADOW = 2,
  localparam int RW        = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [RW-1:0]     in_rs1,
  input  logic [RW-1:0]     in_rs2,
  input  logic [RW-1:0]     in_rd,
  input  logic              in_uses_rs1,
  input  logic              in_uses_rs2,
  input  logic              in_reg_write,
  input  logic              in_is_branch,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [XLEN-1:0]   rs1_val,
  input  logic [XLEN-1:0]   rs2_val,
  input  logic              flush,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [XLEN-1:0]   out_pc,
  output logic [XLEN-1:0]   out_rs1_val,
  output logic [XLEN-1:0]   out_rs2_val,
  output logic [RW-1:0]     out_rd,
  output logic              out_reg_write,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic              stall_out,
  output logic [15:0]       stall_count
);
  logic       advance, issue, hazard, stall_evt;
  logic       rs1_hit, rs2_hit;
  logic [2:0] shadow_cnt;

  hazard_scoreboard #(.HAZ_DEPTH(HAZ_DEPTH), .RW(RW)) u_sb (
    .clk          (clk),
    .rst_n        (rst_n),
    .shift        (advance),
    .insert_valid (issue & in_reg_write & (in_rd != '0)),
    .insert_rd    (in_rd),
    .clear_head   (flush),
    .rs1          (in_rs1),
    .rs2          (in_rs2),
    .rs1_match    (rs1_hit),
    .rs2_match    (rs2_hit)
  );

  assign advance   = out_ready;
  // x0 reads never depend on anything, whatever the scoreboard holds.
  assign hazard    = (in_uses_rs1 & (in_rs1 != '0) & rs1_hit)
                   | (in_uses_rs2 & (in_rs2 != '0) & rs2_hit);
  assign in_ready  = rst_n & out_ready & ~flush & ~hazard & (shadow_cnt == 3'd0);
  assign issue     = in_valid & in_ready;
  assign stall_evt = in_valid & out_ready & ~flush & (hazard | (shadow_cnt != 3'd0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_pc        <= '0;
      out_rs1_val   <= '0;
      out_rs2_val   <= '0;
      out_rd        <= '0;
      out_reg_write <= 1'b0;
      out_ctrl      <= '0;
      shadow_cnt    <= 3'd0;
    end else if (flush) begin
      out_valid     <= 1'b0;
      out_reg_write <= 1'b0;
      out_ctrl      <= CTRL_NOP[CTRL_W-1:0];
      shadow_cnt    <= 3'd0;
    end else if (advance) begin
      if (issue) begin
        out_valid     <= 1'b1;
        out_pc        <= in_pc;
        out_rs1_val   <= rs1_val;
        out_rs2_val   <= rs2_val;
        out_rd        <= in_rd;
        out_reg_write <= in_reg_write;
        out_ctrl      <= in_ctrl;
        // Issue implies the shadow is already empty, so only a branch reloads it.
        if (in_is_branch) shadow_cnt <= 3'(BR_SHADOW);
      end else begin
        out_valid     <= 1'b0;
        out_reg_write <= 1'b0;
        out_ctrl      <= CTRL_NOP[CTRL_W-1:0];
        if (shadow_cnt != 3'd0) shadow_cnt <= shadow_cnt - 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_out   <= 1'b0;
      stall_count <= 16'd0;
    end else begin
      stall_out <= stall_evt;
      if (stall_evt && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_decode_issue_stage.sv
module tb_decode_issue_stage;
  logic        clk, rst_n;
  logic        in_valid, in_ready;
  logic [31:0] in_pc;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic        in_uses_rs1, in_uses_rs2, in_reg_write, in_is_branch;
  logic [23:0] in_ctrl;
  logic [31:0] rs1_val, rs2_val;
  logic        flush, out_ready;
  logic        out_valid;
  logic [31:0] out_pc, out_rs1_val, out_rs2_val;
  logic [4:0]  out_rd;
  logic        out_reg_write;
  logic [23:0] out_ctrl;
  logic        stall_out;
  logic [15:0] stall_count;

  int total = 0;
  int bad   = 0;

  decode_issue_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_uses_rs1(in_uses_rs1), .in_uses_rs2(in_uses_rs2),
    .in_reg_write(in_reg_write), .in_is_branch(in_is_branch),
    .in_ctrl(in_ctrl), .rs1_val(rs1_val), .rs2_val(rs2_val),
    .flush(flush), .out_ready(out_ready),
    .out_valid(out_valid), .out_pc(out_pc),
    .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
    .out_rd(out_rd), .out_reg_write(out_reg_write), .out_ctrl(out_ctrl),
    .stall_out(stall_out), .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc,
                       input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                       input logic u1, input logic u2, input logic wr, input logic br,
                       input logic [23:0] ctrl);
    in_valid     = v;
    in_pc        = pc;
    in_rs1       = r1;
    in_rs2       = r2;
    in_rd        = rd;
    in_uses_rs1  = u1;
    in_uses_rs2  = u2;
    in_reg_write = wr;
    in_is_branch = br;
    in_ctrl      = ctrl;
    rs1_val      = pc ^ 32'h1111_0000;
    rs2_val      = pc ^ 32'h2222_0000;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 32'h40, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 24'h123);
    #12;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_ctrl", out_ctrl, 0);
    chk("rst_stall_out", stall_out, 0);
    chk("rst_stall_count", stall_count, 0);
    idle();
    #1 rst_n = 1'b1;
    tick();

    // back-to-back independent ops
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h100 + 32'(4*i), 5'(20+i), 5'(24+i), 5'(1+i),
            1'b1, 1'b1, 1'b1, 1'b0, 24'h10 + 24'(i));
      #1 chk("b2b_in_ready", in_ready, 1);
      tick();
      chk("b2b_out_valid", out_valid, 1);
      chk("b2b_out_pc", out_pc, 32'h100 + 32'(4*i));
      chk("b2b_out_rd", out_rd, 64'(1+i));
      chk("b2b_rs1_val", out_rs1_val, (32'h100 + 32'(4*i)) ^ 32'h1111_0000);
      chk("b2b_rs2_val", out_rs2_val, (32'h100 + 32'(4*i)) ^ 32'h2222_0000);
      chk("b2b_ctrl", out_ctrl, 24'h10 + 24'(i));
    end
    idle();
    tick();
    chk("b2b_bubble_valid", out_valid, 0);
    chk("b2b_bubble_ctrl", out_ctrl, 0);
    chk("b2b_bubble_wr", out_reg_write, 0);
    tick(); tick();
    chk("b2b_stall_count", stall_count, 0);

    // RAW hazard on x5, depth 3
    drive(1'b1, 32'h200, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 24'h55);
    tick();
    chk("raw_writer_valid", out_valid, 1);
    drive(1'b1, 32'h204, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0, 24'h66);
    for (int i = 0; i < 3; i++) begin
      #1 chk("raw_in_ready_stall", in_ready, 0);
      tick();
      chk("raw_bubble", out_valid, 0);
      chk("raw_stall_out", stall_out, 1);
    end
    #1 chk("raw_in_ready_free", in_ready, 1);
    tick();
    chk("raw_issue_valid", out_valid, 1);
    chk("raw_issue_pc", out_pc, 32'h204);
    chk("raw_stall_out_clr", stall_out, 0);
    chk("raw_stall_count", stall_count, 3);
    idle();
    tick(); tick(); tick();

    // branch shadow of 2
    drive(1'b1, 32'h300, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 24'h77);
    tick();
    chk("br_valid", out_valid, 1);
    drive(1'b1, 32'h304, 5'd20, 5'd21, 5'd22, 1'b1, 1'b1, 1'b1, 1'b0, 24'h78);
    for (int i = 0; i < 2; i++) begin
      #1 chk("br_shadow_ready", in_ready, 0);
      tick();
      chk("br_shadow_bubble", out_valid, 0);
    end
    #1 chk("br_after_ready", in_ready, 1);
    tick();
    chk("br_after_pc", out_pc, 32'h304);
    chk("br_after_valid", out_valid, 1);
    chk("br_stall_count", stall_count, 5);

    // branch, then flush during the first shadow cycle
    drive(1'b1, 32'h310, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 24'h79);
    tick();
    drive(1'b1, 32'h314, 5'd20, 5'd21, 5'd23, 1'b1, 1'b1, 1'b1, 1'b0, 24'h7A);
    flush = 1'b1;
    #1 chk("fl_ready", in_ready, 0);
    tick();
    flush = 1'b0;
    chk("fl_valid", out_valid, 0);
    chk("fl_stall_out", stall_out, 0);
    #1 chk("fl_next_ready", in_ready, 1);
    tick();
    chk("fl_next_valid", out_valid, 1);
    chk("fl_next_pc", out_pc, 32'h314);
    chk("fl_stall_count", stall_count, 5);
    idle();
    tick(); tick(); tick();

    // out_ready low holds everything
    drive(1'b1, 32'h400, 5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0, 24'hABCDE);
    tick();
    drive(1'b1, 32'h404, 5'd20, 5'd21, 5'd24, 1'b1, 1'b1, 1'b1, 1'b0, 24'h11);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1 chk("hold_ready", in_ready, 0);
      tick();
      chk("hold_valid", out_valid, 1);
      chk("hold_pc", out_pc, 32'h400);
      chk("hold_ctrl", out_ctrl, 24'hABCDE);
      chk("hold_rd", out_rd, 7);
    end
    out_ready = 1'b1;
    drive(1'b1, 32'h408, 5'd7, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h12);
    #1 chk("hold_sb_kept", in_ready, 0);
    chk("hold_stall_count", stall_count, 5);
    idle();
    tick(); tick(); tick();

    // x0 write then x0 read
    drive(1'b1, 32'h500, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 24'h21);
    tick();
    drive(1'b1, 32'h504, 5'd0, 5'd0, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0, 24'h22);
    #1 chk("x0_ready", in_ready, 1);
    tick();
    chk("x0_pc", out_pc, 32'h504);
    chk("x0_stall_out", stall_out, 0);
    chk("x0_stall_count", stall_count, 5);
    idle();
    tick(); tick(); tick();

    // reset during a hazard stall
    drive(1'b1, 32'h600, 5'd0, 5'd0, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0, 24'h31);
    tick();
    drive(1'b1, 32'h604, 5'd0, 5'd9, 5'd10, 1'b0, 1'b1, 1'b1, 1'b0, 24'h32);
    #1 chk("rs_pre_ready", in_ready, 0);
    tick();
    chk("rs_pre_stall_out", stall_out, 1);
    chk("rs_pre_count", stall_count, 6);
    rst_n = 1'b0;
    #1;
    chk("rs_out_valid", out_valid, 0);
    chk("rs_out_pc", out_pc, 0);
    chk("rs_stall_out", stall_out, 0);
    chk("rs_stall_count", stall_count, 0);
    chk("rs_in_ready", in_ready, 0);
    tick();
    rst_n = 1'b1;
    #1 chk("rs_post_ready", in_ready, 1);
    tick();
    chk("rs_post_valid", out_valid, 1);
    chk("rs_post_pc", out_pc, 32'h604);
    chk("rs_post_stall_out", stall_out, 0);
    chk("rs_post_count", stall_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
